// File: rtl/ram8_16_pkg.sv
// ram8_16_pkg
//   Shared sizing and reset constants for the ram8_16 family.
//   The larger RAM64/RAM512 blocks are meant to reuse these values.
`timescale 1ns/1ps
package ram8_16_pkg;
  localparam int          WIDTH    = 16;
  localparam int          ADDR_W   = 3;
  localparam int          DEPTH    = 2 ** ADDR_W;
  localparam logic [15:0] RST_WORD = 16'h0000;
endpackage

// File: rtl/ram8_16_if.sv
// ram8_16_if
//   Data/control bundle for the 8-word RAM.
//   in      : write data
//   load    : write enable, sampled on rising clk
//   address : word select for both the write and the read
//   out     : combinational read data of the word at address
//   wr_ack  : high for one cycle after each accepted write
//   master drives in/load/address; slave (the RAM) drives out/wr_ack.
`timescale 1ns/1ps
interface ram8_16_if #(
  parameter int WIDTH  = ram8_16_pkg::WIDTH,
  parameter int ADDR_W = ram8_16_pkg::ADDR_W
);
  logic [WIDTH-1:0]  in;
  logic              load;
  logic [ADDR_W-1:0] address;
  logic [WIDTH-1:0]  out;
  logic              wr_ack;

  modport master (output in, load, address, input out, wr_ack);
  modport slave  (input in, load, address, output out, wr_ack);
endinterface

// File: rtl/ram8_16_register16.sv
// register16
//   One storage word with asynchronous active-low reset.
//   clk   : clock, rising edge
//   rst_n : async reset, active low, clears to RST_VAL
//   in    : data loaded when load=1
//   load  : load enable
//   out   : stored word
`timescale 1ns/1ps
module register16 #(
  parameter int               WIDTH   = ram8_16_pkg::WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  output logic [WIDTH-1:0] out
);
  logic [WIDTH-1:0] q;

  // Conditional operator instead of if(load): an unknown load must not be
  // read as "hold"; it merges the bits that differ to X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= RST_VAL;
    else        q <= load ? in : q;
  end

  assign out = q;
endmodule

// File: rtl/ram8_16.sv
// ram8_16
//   8 x WIDTH RAM built from register16 words.
//   clk   : clock, all state updates on the rising edge
//   rst_n : async reset, active low; clears every word and wr_ack
//   bus   : ram8_16_if slave (in, load, address -> out, wr_ack)
//   Reads are combinational with no write-through, so during a write cycle
//   out shows the old word; the new one appears after the edge.
`timescale 1ns/1ps
module ram8_16 #(
  parameter int WIDTH  = ram8_16_pkg::WIDTH,
  parameter int ADDR_W = ram8_16_pkg::ADDR_W
) (
  input  logic      clk,
  input  logic      rst_n,
  ram8_16_if.slave  bus
);
  import ram8_16_pkg::*;

  localparam int NWORDS = 2 ** ADDR_W;

  logic [NWORDS-1:0] word_load;
  logic [WIDTH-1:0]  words [NWORDS];
  logic              wr_ack_q;

  for (genvar i = 0; i < NWORDS; i++) begin : g_word
    // Equality compare keeps an unknown address visible as an unknown load.
    assign word_load[i] = bus.load & (bus.address == ADDR_W'(i));

    register16 #(
      .WIDTH   (WIDTH),
      .RST_VAL (WIDTH'(RST_WORD))
    ) u_word (
      .clk   (clk),
      .rst_n (rst_n),
      .in    (bus.in),
      .load  (word_load[i]),
      .out   (words[i])
    );
  end

  // An unknown index reads back X rather than a default word.
  assign bus.out = words[bus.address];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_ack_q <= 1'b0;
    else        wr_ack_q <= bus.load;
  end

  assign bus.wr_ack = wr_ack_q;
endmodule

// File: tb/tb_ram8_16.sv
`timescale 1ns/1ps
module tb_ram8_16;
  import ram8_16_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  ram8_16_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

  ram8_16 #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #10 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        ld;
    logic [2:0]  addr;
    logic [15:0] din;
    logic [15:0] pre;
    logic [15:0] post;
    logic        ack;
  } vec_t;

  vec_t vecs [12];

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ld, input logic [2:0] a, input logic [15:0] d);
    bus.load    = ld;
    bus.address = a;
    bus.in      = d;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] img [8];

    rst_n = 1'b0;
    drive(1'b0, 3'd0, 16'h0000);

    // Reset sweep, no clock dependence
    #3;
    for (int a = 0; a < 8; a++) begin
      bus.address = 3'(a);
      #1;
      chk16($sformatf("rst_sweep_a%0d", a), bus.out, 16'h0000);
    end
    chk1("rst_ack", bus.wr_ack, 1'b0);

    // Write attempt during reset is ignored
    drive(1'b1, 3'd1, 16'hCAFE);
    tick();
    chk16("rst_write_ignored", bus.out, 16'h0000);
    chk1("rst_write_ack", bus.wr_ack, 1'b0);

    // Release and write 3 and 7
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 3'd3, 16'hA5A5);
    tick();
    chk1("wr3_ack", bus.wr_ack, 1'b1);
    @(negedge clk);
    drive(1'b1, 3'd7, 16'h0F0F);
    tick();
    chk1("wr7_ack", bus.wr_ack, 1'b1);
    @(negedge clk);
    drive(1'b0, 3'd0, 16'h0000);
    tick();
    chk1("wr_idle_ack", bus.wr_ack, 1'b0);

    for (int a = 0; a < 8; a++) img[a] = 16'h0000;
    img[3] = 16'hA5A5;
    img[7] = 16'h0F0F;
    for (int a = 0; a < 8; a++) begin
      bus.address = 3'(a);
      #1;
      chk16($sformatf("readback_a%0d", a), bus.out, img[a]);
    end

    // Table: same-cycle read, ack width, write-disable, equal-data write
    vecs[0]  = '{1'b1, 3'd5, 16'h1234, 16'h0000, 16'h1234, 1'b1};
    vecs[1]  = '{1'b1, 3'd5, 16'hFFFF, 16'h1234, 16'hFFFF, 1'b1};
    vecs[2]  = '{1'b0, 3'd5, 16'h0000, 16'hFFFF, 16'hFFFF, 1'b0};
    vecs[3]  = '{1'b0, 3'd2, 16'hDEAD, 16'h0000, 16'h0000, 1'b0};
    vecs[4]  = '{1'b0, 3'd2, 16'hDEAD, 16'h0000, 16'h0000, 1'b0};
    vecs[5]  = '{1'b0, 3'd2, 16'hDEAD, 16'h0000, 16'h0000, 1'b0};
    vecs[6]  = '{1'b0, 3'd2, 16'hDEAD, 16'h0000, 16'h0000, 1'b0};
    vecs[7]  = '{1'b0, 3'd2, 16'hDEAD, 16'h0000, 16'h0000, 1'b0};
    vecs[8]  = '{1'b1, 3'd3, 16'hA5A5, 16'hA5A5, 16'hA5A5, 1'b1};
    vecs[9]  = '{1'b0, 3'd3, 16'h0000, 16'hA5A5, 16'hA5A5, 1'b0};
    vecs[10] = '{1'b1, 3'd7, 16'h0000, 16'h0F0F, 16'h0000, 1'b1};
    vecs[11] = '{1'b0, 3'd7, 16'h5555, 16'h0000, 16'h0000, 1'b0};

    for (int v = 0; v < 12; v++) begin
      @(negedge clk);
      drive(vecs[v].ld, vecs[v].addr, vecs[v].din);
      #1;
      chk16($sformatf("vec%0d_pre", v), bus.out, vecs[v].pre);
      tick();
      chk16($sformatf("vec%0d_post", v), bus.out, vecs[v].post);
      chk1($sformatf("vec%0d_ack", v), bus.wr_ack, vecs[v].ack);
    end

    // Back-to-back writes keep wr_ack high
    for (int a = 0; a < 8; a++) begin
      @(negedge clk);
      drive(1'b1, 3'(a), 16'(a) * 16'h1111);
      tick();
      chk1($sformatf("b2b_ack%0d", a), bus.wr_ack, 1'b1);
    end
    @(negedge clk);
    drive(1'b0, 3'd0, 16'h0000);
    tick();
    chk1("b2b_ack_drop", bus.wr_ack, 1'b0);
    for (int a = 0; a < 8; a++) begin
      bus.address = 3'(a);
      #1;
      chk16($sformatf("b2b_read_a%0d", a), bus.out, 16'(a) * 16'h1111);
    end

    // Fill with FFFF, then async reset between edges with a write pending
    for (int a = 0; a < 8; a++) begin
      @(negedge clk);
      drive(1'b1, 3'(a), 16'hFFFF);
      tick();
    end
    @(negedge clk);
    drive(1'b1, 3'd4, 16'h1234);
    #1;
    chk16("fill_a4", bus.out, 16'hFFFF);
    rst_n = 1'b0;
    #0.5;
    chk1("async_rst_ack", bus.wr_ack, 1'b0);
    for (int a = 0; a < 8; a++) begin
      bus.address = 3'(a);
      #0.5;
      chk16($sformatf("async_rst_a%0d", a), bus.out, 16'h0000);
    end
    bus.address = 3'd4;
    tick();
    chk16("rst_lost_write", bus.out, 16'h0000);
    chk1("rst_lost_ack", bus.wr_ack, 1'b0);

    // First edge after release accepts a write
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 3'd6, 16'hBEEF);
    tick();
    chk16("first_write_data", bus.out, 16'hBEEF);
    chk1("first_write_ack", bus.wr_ack, 1'b1);
    @(negedge clk);
    drive(1'b0, 3'd4, 16'h0000);
    #1;
    chk16("post_rst_a4", bus.out, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ram8_16.md
RAM8_16 -- requirements
Module: ram8_16

Interface
REQ-001 Parameter WIDTH, default 16: word width in bits; the design SHALL be verified at 16 only.
REQ-002 Parameter ADDR_W, default 3: address width; depth = 2**ADDR_W = 8 words.
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on its rising edge only.
REQ-004 Port rst_n, input, 1: reset; reset SHALL be asynchronous and active-low.
REQ-005 Port in, input, WIDTH: write data.
REQ-006 Port load, input, 1: write enable, sampled at the rising edge of clk.
REQ-007 Port address, input, ADDR_W: selects the word for both the write and the read.
REQ-008 Port out, output, WIDTH: read data, equal to the word at address.
REQ-009 Port wr_ack, output, 1: pulses high for one cycle after each accepted write.

Function
REQ-010 Storage SHALL be 8 independent WIDTH-bit registers, reg[0]..reg[7].
REQ-011 On a rising edge with load=1, reg[address] SHALL take the value of in; all other words SHALL be unchanged.
REQ-012 On a rising edge with load=0, no word SHALL change.
REQ-013 out SHALL be a combinational read of reg[address], with zero-cycle latency on address changes.
REQ-014 Write-then-read in the same cycle: during a cycle with load=1, out SHALL show the old value; the new value SHALL appear only after the edge (no write-through bypass).
REQ-015 wr_ack SHALL be registered: 1 in the cycle after an edge where load=1, otherwise 0; back-to-back writes SHALL hold wr_ack at 1 continuously.
REQ-016 All 8 address values are legal; there is no out-of-range condition and no wrap logic.
REQ-017 X or Z on address or load SHALL NOT be silently masked; simulation SHALL propagate X onto out and onto the affected storage.
REQ-018 A write whose data equals the stored value SHALL still assert wr_ack.

Reset
REQ-019 While rst_n=0, all 8 words SHALL read 16'h0000 and wr_ack SHALL be 0, with no dependence on clk.
REQ-020 Reset mid-write: when rst_n falls in the same cycle as load=1, the write SHALL be discarded.
REQ-021 Writes SHALL be accepted from the first rising edge at which rst_n=1.
REQ-022 During reset, out SHALL still follow address combinationally and SHALL read 0.

Structure
REQ-023 A sub-module register16 SHALL hold each word (clk, rst_n, in, load, out); it SHALL be instantiated 8 times.
REQ-024 Per-word load SHALL be derived by a 3-to-8 decode of address gated by load.
REQ-025 The read path SHALL be an 8-to-1 WIDTH-bit multiplexer.
REQ-026 A shared package SHALL define WIDTH=16, ADDR_W=3, DEPTH=8 and the reset word value RST_WORD=16'h0000, for reuse by later RAM64/RAM512 blocks.

Verification
REQ-027 Reset: hold rst_n=0, sweep address 0..7 -> out=16'h0000 at each address; wr_ack=0.
REQ-028 Write/readback: write 16'hA5A5 to address 3, then 16'h0F0F to address 7; read all 8 addresses -> only words 3 and 7 are nonzero and hold exactly those values.
REQ-029 Same-cycle read: address=5 holding 16'h1234, load=1 with in=16'hFFFF -> out=16'h1234 before the edge and 16'hFFFF after it; wr_ack=1 for exactly one cycle.
REQ-030 Write-enable off: load=0, in=16'hDEAD, address=2, run 5 cycles -> word 2 unchanged, wr_ack stays 0.
REQ-031 Async reset mid-operation: fill all words with 16'hFFFF, drop rst_n between clock edges -> every word reads 0 immediately, and a coincident write is lost.
REQ-032 Back-to-back writes: write to addresses 0..7 on consecutive cycles with in=address*16'h1111 -> wr_ack stays high for 8 cycles; readback matches each word.
